// File: rtl/basket_pkg.sv
// Shared constants, types and the saturating quantity adder for the shopping basket.
// Imported by the basket controller and its entry store.
package basket_pkg;

    localparam int MAX_ITEMS    = 8;
    localparam int IDX_W        = $clog2(MAX_ITEMS);
    localparam int QTY_MAX      = 15;
    localparam int PRODUCT_ID_W = 4;
    localparam int QTY_W        = 4;
    localparam int CNT_W        = 4;
    localparam int MEM_DEPTH    = 2 ** IDX_W;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITEMS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        UPDATE = 3'd2,
        APPEND = 3'd3,
        SHIFT  = 3'd4,
        CLR    = 3'd5,
        FINISH = 3'd6
    } state_e;

    typedef struct packed {
        logic [PRODUCT_ID_W-1:0] id;
        logic [QTY_W-1:0]        qty;
    } entry_t;

    typedef struct packed {
        logic [QTY_W-1:0] qty;
        logic             sat;
    } sat_sum_t;

    // Widen by one bit so an overflow is visible, then clip at the ceiling.
    function automatic sat_sum_t basket_sat_add(
        input logic [QTY_W-1:0] a,
        input logic [QTY_W-1:0] b
    );
        logic [QTY_W:0] sum_s;
        sat_sum_t       res_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s > (QTY_W + 1)'(QTY_MAX)) begin
            res_s.qty = QTY_W'(QTY_MAX);
            res_s.sat = 1'b1;
        end else begin
            res_s.qty = sum_s[QTY_W-1:0];
            res_s.sat = 1'b0;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/basket_controller_store.sv
// Entry array for the basket: one write port, one combinational lookup for the
// controller, and a registered display read port.
module basket_controller_store
    import basket_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  entry_t           wr_entry,
    input  logic [IDX_W-1:0] look_idx,
    output entry_t           look_entry,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [CNT_W-1:0] count,
    output entry_t           rd_entry,
    output logic             rd_valid
);

    localparam entry_t ENTRY_ZERO = '{id: {PRODUCT_ID_W{1'b0}}, qty: {QTY_W{1'b0}}};

    // Sized to the full index range so no address can fall outside the array.
    entry_t mem_r [MEM_DEPTH];
    entry_t rd_entry_r;
    logic   rd_valid_r;

    // Entry array write port.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= wr_entry;
        end else begin
            mem_r[wr_idx] <= mem_r[wr_idx];
        end
    end

    // Display read port, one cycle behind rd_index.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_entry_r <= ENTRY_ZERO;
            rd_valid_r <= 1'b0;
        end else begin
            rd_entry_r <= mem_r[rd_index];
            rd_valid_r <= (CNT_W'(rd_index) < count);
        end
    end

    assign look_entry = mem_r[look_idx];
    assign rd_entry   = rd_entry_r;
    assign rd_valid   = rd_valid_r;

endmodule

// File: rtl/basket_controller.sv
// Shopping-basket controller: merges repeat products, appends new ones, deletes
// with compaction and reports the entry count to the terminal state machine.
module basket_controller
    import basket_pkg::*;
(
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    add_en,
    input  logic [PRODUCT_ID_W-1:0] add_product_id,
    input  logic [QTY_W-1:0]        add_qty,
    input  logic                    del_en,
    input  logic [IDX_W-1:0]        del_index,
    input  logic                    clear,
    input  logic [IDX_W-1:0]        rd_index,
    output logic [PRODUCT_ID_W-1:0] rd_product_id,
    output logic [QTY_W-1:0]        rd_qty,
    output logic                    rd_valid,
    output logic [CNT_W-1:0]        BasketProductNum,
    output logic                    busy,
    output logic                    done,
    output logic                    err_full,
    output logic                    err_index,
    output logic                    sat
);

    state_e                  state_r;
    state_e                  state_s;
    logic [CNT_W-1:0]        ptr_r;
    logic [CNT_W-1:0]        ptr_s;
    logic [CNT_W-1:0]        ptr_inc_s;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_s;
    logic [PRODUCT_ID_W-1:0] lat_id_r;
    logic [PRODUCT_ID_W-1:0] lat_id_s;
    logic [QTY_W-1:0]        lat_qty_r;
    logic [QTY_W-1:0]        lat_qty_s;

    logic                    wr_en_s;
    logic [IDX_W-1:0]        wr_idx_s;
    entry_t                  wr_entry_s;
    logic [IDX_W-1:0]        look_idx_s;
    entry_t                  look_entry_s;
    entry_t                  rd_entry_s;
    logic                    rd_valid_s;
    sat_sum_t                upd_sum_s;

    logic                    err_full_s;
    logic                    err_index_s;
    logic                    sat_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_full_r;
    logic                    err_index_r;
    logic                    sat_r;

    basket_controller_store u_store (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .wr_en      (wr_en_s),
        .wr_idx     (wr_idx_s),
        .wr_entry   (wr_entry_s),
        .look_idx   (look_idx_s),
        .look_entry (look_entry_s),
        .rd_index   (rd_index),
        .count      (count_r),
        .rd_entry   (rd_entry_s),
        .rd_valid   (rd_valid_s)
    );

    // Next-state, datapath control and completion flags.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        count_s     = count_r;
        lat_id_s    = lat_id_r;
        lat_qty_s   = lat_qty_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = ptr_r[IDX_W-1:0];
        wr_entry_s  = '{id: lat_id_r, qty: lat_qty_r};
        look_idx_s  = ptr_r[IDX_W-1:0];
        err_full_s  = 1'b0;
        err_index_s = 1'b0;
        sat_s       = 1'b0;
        ptr_inc_s   = ptr_r + 4'd1;
        upd_sum_s   = basket_sat_add(look_entry_s.qty, lat_qty_r);

        case (state_r)
            IDLE: begin
                if (clear) begin
                    state_s = CLR;
                end else if (add_en) begin
                    lat_id_s  = add_product_id;
                    lat_qty_s = add_qty;
                    ptr_s     = 4'd0;
                    state_s   = SEARCH;
                end else if (del_en) begin
                    if (CNT_W'(del_index) >= count_r) begin
                        err_index_s = 1'b1;
                        state_s     = FINISH;
                    end else begin
                        ptr_s   = CNT_W'(del_index);
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEARCH: begin
                if (ptr_r == count_r) begin
                    state_s = APPEND;
                end else if (look_entry_s.id == lat_id_r) begin
                    state_s = UPDATE;
                end else begin
                    ptr_s = ptr_inc_s;
                end
            end
            UPDATE: begin
                wr_en_s    = 1'b1;
                wr_entry_s = '{id: lat_id_r, qty: upd_sum_s.qty};
                sat_s      = upd_sum_s.sat;
                state_s    = FINISH;
            end
            APPEND: begin
                if (count_r == MAX_CNT) begin
                    err_full_s = 1'b1;
                end else begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = count_r[IDX_W-1:0];
                    count_s  = count_r + 4'd1;
                end
                state_s = FINISH;
            end
            SHIFT: begin
                // Pull the next entry down one slot per cycle to close the gap.
                look_idx_s = ptr_inc_s[IDX_W-1:0];
                if (ptr_inc_s < count_r) begin
                    wr_en_s    = 1'b1;
                    wr_entry_s = look_entry_s;
                    ptr_s      = ptr_inc_s;
                end else begin
                    if (count_r != 4'd0) begin
                        count_s = count_r - 4'd1;
                    end else begin
                        count_s = 4'd0;
                    end
                    state_s = FINISH;
                end
            end
            CLR: begin
                count_s = 4'd0;
                state_s = FINISH;
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_r     <= IDLE;
            ptr_r       <= 4'd0;
            count_r     <= 4'd0;
            lat_id_r    <= {PRODUCT_ID_W{1'b0}};
            lat_qty_r   <= {QTY_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_full_r  <= 1'b0;
            err_index_r <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            count_r     <= count_s;
            lat_id_r    <= lat_id_s;
            lat_qty_r   <= lat_qty_s;
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == FINISH);
            err_full_r  <= err_full_s;
            err_index_r <= err_index_s;
            sat_r       <= sat_s;
        end
    end

    assign rd_product_id    = rd_entry_s.id;
    assign rd_qty           = rd_entry_s.qty;
    assign rd_valid         = rd_valid_s;
    assign BasketProductNum = count_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err_full         = err_full_r;
    assign err_index        = err_index_r;
    assign sat              = sat_r;

endmodule

// File: tb/tb_basket_controller.sv
// Self-checking bench for basket_controller: directed vector table, corner-case
// sequences and randomized operations against a queue-based basket model.
module tb_basket_controller;

    localparam int K_ADD    = 0;
    localparam int K_DEL    = 1;
    localparam int K_CLR    = 2;
    localparam int K_ADDDEL = 3;
    localparam int K_CLRADD = 4;

    typedef struct {
        int         kind;
        logic [3:0] id;
        logic [3:0] qty;
        logic [2:0] idx;
        int         lat;
        logic       e_full;
        logic       e_idx;
        logic       e_sat;
        int         cnt;
        int         chk_idx;
        logic [3:0] chk_id;
        logic [3:0] chk_qty;
    } vec_t;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       add_en;
    logic [3:0] add_product_id;
    logic [3:0] add_qty;
    logic       del_en;
    logic [2:0] del_index;
    logic       clear;
    logic [2:0] rd_index;
    logic [3:0] rd_product_id;
    logic [3:0] rd_qty;
    logic       rd_valid;
    logic [3:0] BasketProductNum;
    logic       busy;
    logic       done;
    logic       err_full;
    logic       err_index;
    logic       sat;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] m_id[$];
    logic [3:0] m_qty[$];
    vec_t       vecs[$];

    basket_controller dut (
        .CLOCK_50         (CLOCK_50),
        .RESET            (RESET),
        .add_en           (add_en),
        .add_product_id   (add_product_id),
        .add_qty          (add_qty),
        .del_en           (del_en),
        .del_index        (del_index),
        .clear            (clear),
        .rd_index         (rd_index),
        .rd_product_id    (rd_product_id),
        .rd_qty           (rd_qty),
        .rd_valid         (rd_valid),
        .BasketProductNum (BasketProductNum),
        .busy             (busy),
        .done             (done),
        .err_full         (err_full),
        .err_index        (err_index),
        .sat              (sat)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input int kind, input int id, input int q, input int idx,
                                input int lat, input int ef, input int ei, input int es,
                                input int cnt, input int ci, input int cid, input int cq);
        vec_t v;
        v.kind = kind;        v.id = 4'(id);       v.qty = 4'(q);       v.idx = 3'(idx);
        v.lat = lat;          v.e_full = ef[0];    v.e_idx = ei[0];     v.e_sat = es[0];
        v.cnt = cnt;          v.chk_idx = ci;      v.chk_id = 4'(cid);  v.chk_qty = 4'(cq);
        return v;
    endfunction

    // Basket behaviour as list operations: merge, append, delete-with-compaction, clear.
    task automatic model_op(input int kind, input logic [3:0] id, input logic [3:0] q,
                            input logic [2:0] idx, output int lat,
                            output logic ef, output logic ei, output logic es);
        int k;
        int s;
        ef = 1'b0; ei = 1'b0; es = 1'b0; lat = 0;
        if (kind == K_CLR || kind == K_CLRADD) begin
            m_id.delete();
            m_qty.delete();
            lat = 2;
        end else if (kind == K_ADD || kind == K_ADDDEL) begin
            k = -1;
            foreach (m_id[i]) if (k < 0 && m_id[i] == id) k = i;
            if (k >= 0) begin
                s = int'(m_qty[k]) + int'(q);
                if (s > 15) begin es = 1'b1; s = 15; end
                m_qty[k] = 4'(s);
                lat = k + 3;
            end else begin
                lat = m_id.size() + 3;
                if (m_id.size() == 8) ef = 1'b1;
                else begin m_id.push_back(id); m_qty.push_back(q); end
            end
        end else begin
            if (int'(idx) >= m_id.size()) begin
                ei = 1'b1;
                lat = 1;
            end else begin
                lat = m_id.size() - 1 - int'(idx) + 2;
                m_id.delete(int'(idx));
                m_qty.delete(int'(idx));
            end
        end
    endtask

    // Pulse a command and follow it to its done cycle; optionally inject commands while busy.
    task automatic run_op(input int kind, input logic [3:0] id, input logic [3:0] q,
                          input logic [2:0] idx, input bit inject, output int lat,
                          output logic ef, output logic ei, output logic es, output bit proto_ok);
        add_product_id = id; add_qty = q; del_index = idx;
        add_en = (kind == K_ADD || kind == K_ADDDEL || kind == K_CLRADD);
        del_en = (kind == K_DEL || kind == K_ADDDEL);
        clear  = (kind == K_CLR || kind == K_CLRADD);
        @(posedge CLOCK_50); #1;
        add_en = 1'b0; del_en = 1'b0; clear = 1'b0;
        lat = -1; ef = 1'b0; ei = 1'b0; es = 1'b0; proto_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (busy !== 1'b1) proto_ok = 1'b0;
            if (done === 1'b1) begin
                lat = c; ef = err_full; ei = err_index; es = sat;
                break;
            end
            if ((err_full | err_index | sat) !== 1'b0) proto_ok = 1'b0;
            if (inject && c == 1) begin
                add_en = 1'b1; del_en = 1'b1; clear = 1'b1;
                add_product_id = 4'd12; add_qty = 4'd3; del_index = 3'd0;
            end
            @(posedge CLOCK_50); #1;
            add_en = 1'b0; del_en = 1'b0; clear = 1'b0;
        end
        @(posedge CLOCK_50); #1;
        if (busy !== 1'b0 || done !== 1'b0) proto_ok = 1'b0;
    endtask

    task automatic check_contents(input string tag);
        check({tag, " count"}, 32'(BasketProductNum), 32'(m_id.size()));
        for (int i = 0; i < 8; i++) begin
            rd_index = 3'(i);
            @(posedge CLOCK_50); #1;
            check($sformatf("%s rd_valid[%0d]", tag, i), 32'(rd_valid), 32'(i < m_id.size()));
            if (i < m_id.size()) begin
                check($sformatf("%s id[%0d]", tag, i), 32'(rd_product_id), 32'(m_id[i]));
                check($sformatf("%s qty[%0d]", tag, i), 32'(rd_qty), 32'(m_qty[i]));
            end
        end
    endtask

    task automatic model_run(input string tag, input int kind, input logic [3:0] id,
                             input logic [3:0] q, input logic [2:0] idx, input bit inject);
        int   elat, alat;
        logic ef, ei, es, af, ai, as_;
        bit   pok;
        model_op(kind, id, q, idx, elat, ef, ei, es);
        run_op(kind, id, q, idx, inject, alat, af, ai, as_, pok);
        check({tag, " latency"}, 32'(alat), 32'(elat));
        check({tag, " err_full"}, 32'(af), 32'(ef));
        check({tag, " err_index"}, 32'(ai), 32'(ei));
        check({tag, " sat"}, 32'(as_), 32'(es));
        check({tag, " busy/done protocol"}, 32'(pok), 32'd1);
        check_contents(tag);
    endtask

    initial begin
        int   alat, dl;
        logic af, ai, as_, ef, ei, es;
        bit   pok, saw_done;

        RESET = 1'b1; add_en = 1'b0; add_product_id = 4'd0; add_qty = 4'd0;
        del_en = 1'b0; del_index = 3'd0; clear = 1'b0; rd_index = 3'd0;

        // Directed vectors: expected values worked out by hand from the basket rules.
        vecs.push_back(mk(K_ADD, 3, 2, 0, 3, 0, 0, 0, 1, 0, 3, 2));
        vecs.push_back(mk(K_ADD, 3, 4, 0, 3, 0, 0, 0, 1, 0, 3, 6));
        vecs.push_back(mk(K_ADD, 3, 4, 0, 3, 0, 0, 0, 1, 0, 3, 10));
        vecs.push_back(mk(K_ADD, 3, 4, 0, 3, 0, 0, 0, 1, 0, 3, 14));
        vecs.push_back(mk(K_ADD, 3, 4, 0, 3, 0, 0, 1, 1, 0, 3, 15));
        vecs.push_back(mk(K_CLR, 0, 0, 0, 2, 0, 0, 0, 0, -1, 0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(K_ADD, i, 1, 0, i + 2, 0, 0, 0, i, i - 1, i, 1));
        vecs.push_back(mk(K_ADD, 9, 1, 0, 11, 1, 0, 0, 8, 7, 8, 1));
        vecs.push_back(mk(K_ADD, 5, 3, 0, 7, 0, 0, 0, 8, 4, 5, 4));
        vecs.push_back(mk(K_CLR, 0, 0, 0, 2, 0, 0, 0, 0, -1, 0, 0));
        for (int i = 1; i <= 4; i++)
            vecs.push_back(mk(K_ADD, i, 1, 0, i + 2, 0, 0, 0, i, i - 1, i, 1));
        vecs.push_back(mk(K_DEL, 0, 0, 1, 4, 0, 0, 0, 3, 1, 3, 1));
        vecs.push_back(mk(K_DEL, 0, 0, 5, 1, 0, 1, 0, 3, 2, 4, 1));
        vecs.push_back(mk(K_DEL, 0, 0, 2, 2, 0, 0, 0, 2, 1, 3, 1));
        vecs.push_back(mk(K_ADD, 7, 0, 0, 5, 0, 0, 0, 3, 2, 7, 0));
        vecs.push_back(mk(K_DEL, 0, 0, 0, 4, 0, 0, 0, 2, 0, 3, 1));

        repeat (3) @(posedge CLOCK_50);
        #1 RESET = 1'b0;
        check("reset count", 32'(BasketProductNum), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset flags", 32'({err_full, err_index, sat}), 32'd0);
        check("reset rd", 32'({rd_valid, rd_product_id, rd_qty}), 32'd0);

        foreach (vecs[v]) begin
            model_op(vecs[v].kind, vecs[v].id, vecs[v].qty, vecs[v].idx, dl, ef, ei, es);
            run_op(vecs[v].kind, vecs[v].id, vecs[v].qty, vecs[v].idx, 1'b0, alat, af, ai, as_, pok);
            check($sformatf("vec%0d latency", v), 32'(alat), 32'(vecs[v].lat));
            check($sformatf("vec%0d err_full", v), 32'(af), 32'(vecs[v].e_full));
            check($sformatf("vec%0d err_index", v), 32'(ai), 32'(vecs[v].e_idx));
            check($sformatf("vec%0d sat", v), 32'(as_), 32'(vecs[v].e_sat));
            check($sformatf("vec%0d protocol", v), 32'(pok), 32'd1);
            check($sformatf("vec%0d count", v), 32'(BasketProductNum), 32'(vecs[v].cnt));
            if (vecs[v].chk_idx >= 0) begin
                rd_index = 3'(vecs[v].chk_idx);
                @(posedge CLOCK_50); #1;
                check($sformatf("vec%0d chk valid", v), 32'(rd_valid), 32'd1);
                check($sformatf("vec%0d chk id", v), 32'(rd_product_id), 32'(vecs[v].chk_id));
                check($sformatf("vec%0d chk qty", v), 32'(rd_qty), 32'(vecs[v].chk_qty));
            end
            check_contents($sformatf("vec%0d", v));
        end

        // Commands arriving while busy are dropped; add beats del in the same idle cycle.
        model_run("busy drop", K_ADD, 4'd10, 4'd2, 3'd0, 1'b1);
        model_run("add+del", K_ADDDEL, 4'd11, 4'd1, 3'd0, 1'b0);
        model_run("clear+add", K_CLRADD, 4'd6, 4'd1, 3'd0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int r;
            logic [3:0] rid, rq;
            logic [2:0] ridx;
            r    = int'($urandom_range(0, 99));
            rid  = 4'($urandom_range(0, 9));
            rq   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            ridx = 3'($urandom_range(0, 7));
            model_run($sformatf("rand%0d", n), (r < 60) ? K_ADD : (r < 93) ? K_DEL : K_CLR,
                      rid, rq, ridx, 1'b0);
        end

        // Reset in the middle of a delete compaction.
        model_run("pre-shift clear", K_CLR, 4'd0, 4'd0, 3'd0, 1'b0);
        for (int i = 1; i <= 5; i++) model_run("pre-shift add", K_ADD, 4'(i), 4'd1, 3'd0, 1'b0);
        del_en = 1'b1; del_index = 3'd0;
        @(posedge CLOCK_50); #1;
        del_en = 1'b0;
        @(posedge CLOCK_50); #1;
        check("mid-shift busy", 32'(busy), 32'd1);
        RESET = 1'b1;
        @(posedge CLOCK_50); #1;
        RESET = 1'b0;
        check("shift reset count", 32'(BasketProductNum), 32'd0);
        check("shift reset busy", 32'(busy), 32'd0);
        check("shift reset done", 32'(done), 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLOCK_50); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        check("no done after reset", 32'(saw_done), 32'd0);
        m_id.delete();
        m_qty.delete();
        check_contents("after shift reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/basket_controller.md
Name: basket_controller

Overview:
- Downstream of the terminal state machine: consumes its product-ID / quantity / enable-pulse triple and maintains the shopping basket.
- Holds up to MAX_ITEMS entries of {product ID, quantity}. Merges repeat products, deletes entries on request and compacts the list.
- Reports the entry count back to the state machine and the interactive-selection logic. Exposes a read port for the VGA/text display.

Parameters:
- MAX_ITEMS, 8, basket capacity in entries (2..15).
- IDX_W, 3, index width, equals clog2(MAX_ITEMS).
- QTY_MAX, 15, saturation ceiling for a per-entry quantity (4-bit field).

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- add_en  in  1  one-cycle pulse: add add_qty units of add_product_id.
- add_product_id  in  4  product ID to add.
- add_qty  in  4  quantity to add (1..4 from keys; 0 legal).
- del_en  in  1  one-cycle pulse: remove entry del_index.
- del_index  in  IDX_W  entry to remove.
- clear  in  1  one-cycle pulse: empty the basket.
- rd_index  in  IDX_W  display read address.
- rd_product_id  out  4  registered ID at rd_index.
- rd_qty  out  4  registered quantity at rd_index.
- rd_valid  out  1  registered, rd_index < count.
- BasketProductNum  out  4  current entry count, 0..MAX_ITEMS.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when an operation completes.
- err_full  out  1  one-cycle pulse with done: add rejected, basket full.
- err_index  out  1  one-cycle pulse with done: del_index >= count.
- sat  out  1  one-cycle pulse with done: quantity clipped at QTY_MAX.

Behaviour:
- Reset: all outputs 0, count 0, every entry valid bit cleared, FSM to IDLE. RESET mid-operation aborts the operation; no done pulse is issued.
- Storage: arrays id[MAX_ITEMS] and qty[MAX_ITEMS]. Entries 0..count-1 are valid; contents above count are don't-care.
- Command priority, sampled in IDLE only: clear > add_en > del_en. The lower-priority command in the same cycle is dropped. Commands arriving while busy=1 are dropped silently.
- States:
  - IDLE: busy=0.
    - clear -> CLR.
    - add_en -> latch ID/qty, scan ptr=0, go to SEARCH.
    - del_en -> latch index. If index >= count, go to FINISH with err_index. Else ptr=index, go to SHIFT.
  - SEARCH: one entry compared per cycle.
    - ptr==count (no match) -> APPEND.
    - id[ptr]==latched ID -> UPDATE.
    - else ptr++.
  - UPDATE: qty[ptr] = min(qty[ptr]+add_qty, QTY_MAX). Use a 5-bit sum; set sat if sum > QTY_MAX. -> FINISH.
  - APPEND: if count==MAX_ITEMS, err_full -> FINISH. Else id[count]=ID, qty[count]=add_qty, count++ -> FINISH.
  - SHIFT: while ptr < count-1, entry[ptr]=entry[ptr+1] and ptr++, one move per cycle. Then count-- -> FINISH.
  - CLR: count=0 -> FINISH.
  - FINISH: done=1 plus the applicable error/sat flag for exactly this cycle -> IDLE.
- add_qty==0 goes through the normal path. It appends a zero-quantity entry if the product is new (the state machine never issues it; legal behaviour).
- Latency, from pulse cycle to done cycle:
  - add, match at k: k+3.
  - add, new entry: count+3.
  - delete index i: (count-1-i)+2.
  - clear: 2.
  - busy is high from the cycle after the pulse through the done cycle.
- BasketProductNum updates on the same edge as the entry write. It is stable while busy for searches only.
- Read port: rd_* registered one cycle after rd_index. Reads during SHIFT may return transient data; the display refreshes continuously.
- Wrap-around: none. ptr never exceeds MAX_ITEMS; count never exceeds MAX_ITEMS or underflows below 0.

Decomposition:
- Shared package basket_pkg:
  - constants MAX_ITEMS, QTY_MAX, IDX_W, PRODUCT_ID_W=4, QTY_W=4.
  - FSM state encoding {IDLE, SEARCH, UPDATE, APPEND, SHIFT, CLR, FINISH}.
  - entry struct {id, qty}.
- No sub-module is required. The saturating adder is a small function in the package, basket_sat_add, so the state machine's quantity path can reuse it.

Test Plan:
- Reset, then add ID 3 qty 2 -> done at cycle 3; BasketProductNum=1; read idx0 = {3,2}, rd_valid=1.
- Add ID 3 qty 4 three times onto {3,2} -> quantities 6, 10, 14. Fourth add -> qty 15 with sat pulse; count stays 1.
- Fill with IDs 1..8 -> count=8. Add ID 9 -> err_full with done; count=8; contents unchanged.
- Basket {1,2,3,4}, delete index 1 -> done after 4 cycles; basket {1,3,4}; count=3. Delete index 5 -> err_index; no change.
- add_en while busy, and add_en+del_en together in IDLE -> only the add executes. Then clear -> count=0 and rd_valid=0 for all indices.
- Assert RESET during SHIFT -> next cycle count=0, busy=0, no done pulse.
